// File: rtl/trace_pkg.sv
// trace_pkg: shared record type, packet constants and serializer states for the retire trace
package trace_pkg;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] wdata;
    } trace_rec_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int         PKT_BYTES = 10;

    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} tx_state_t;

    // Byte i of the on-wire packet: sync, {000,rd}, pc LSB-first, wdata LSB-first
    function automatic logic [7:0] pkt_byte(trace_rec_t r, logic [3:0] i);
        logic [79:0] p;
        p = {r.wdata, r.pc, 3'b000, r.rd, SYNC_BYTE};
        return p[{i, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/retire_trace_uart_if.sv
// retire_trace_uart_if: retirement trace bus from the core to the trace capture block
//   valid : one-cycle pulse per retired write-back
//   pc    : PC of the retiring instruction
//   rd    : destination register
//   wdata : write-back value
interface retire_trace_uart_if;
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] wdata;
    modport master (output valid, pc, rd, wdata);
    modport slave  (input  valid, pc, rd, wdata);
endinterface

// File: rtl/trace_fifo.sv
// trace_fifo: synchronous FIFO that accepts push+pop together even when full
//   clk, rst_n        : clock, async active-low reset
//   push, wdata       : write request and data (ignored when full unless popping)
//   pop, rdata        : read request and head-of-queue data
//   full, empty, count: occupancy status
module trace_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 69
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           wdata,
    output logic [W-1:0]           rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= do_push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= do_pop ? rd_ptr + AW'(1) : rd_ptr;
            count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= wdata;
endmodule

// File: rtl/retire_trace_uart.sv
// retire_trace_uart: captures retired write-backs and streams them as 10-byte 8N1 UART packets
//   clk, rst_n : clock, async active-low reset
//   trace      : retirement trace bus (slave side), never back-pressured
//   uart_tx    : serial output, idle high
//   busy       : serializer not in IDLE
//   fifo_count : buffered records
//   overflow   : sticky drop flag
//   drop_count : dropped records, saturating at 255
module retire_trace_uart import trace_pkg::*; #(
    parameter int DEPTH        = 8,
    parameter int CLKS_PER_BIT = 104
) (
    input  logic                   clk,
    input  logic                   rst_n,
    retire_trace_uart_if.slave     trace,
    output logic                   uart_tx,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow,
    output logic [7:0]             drop_count
);
    localparam int             BW       = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0]  BAUD_MAX = BW'(CLKS_PER_BIT - 1);
    tx_state_t                 state;
    trace_rec_t                rec_in, pkt;
    logic [$bits(trace_rec_t)-1:0] rdata;
    logic                      full, empty, pop, drop, baud_end;
    logic [BW-1:0]             baud_cnt;
    logic [2:0]                bit_idx;
    logic [3:0]                byte_idx;
    logic [7:0]                cur_byte;
    assign rec_in   = {trace.rd, trace.pc, trace.wdata};
    assign pop      = state == IDLE && !empty;
    // A pop in the same cycle frees a slot, so only a full FIFO with no pop drops
    assign drop     = trace.valid && full && !pop;
    assign baud_end = baud_cnt == BAUD_MAX;
    assign cur_byte = pkt_byte(pkt, byte_idx);
    trace_fifo #(.DEPTH(DEPTH), .W($bits(trace_rec_t))) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (trace.valid),
        .pop   (pop),
        .wdata (rec_in),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow   <= 1'b1;
            drop_count <= drop_count == 8'hFF ? drop_count : drop_count + 8'd1;
        end
    // The popped head is captured at the pop edge, since the read pointer moves on that edge
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state    <= IDLE;
            uart_tx  <= 1'b1;
            busy     <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            pkt      <= '0;
        end else begin
            baud_cnt <= baud_end || state == IDLE || state == LOAD ? '0 : baud_cnt + BW'(1);
            case (state)
                IDLE: if (pop) begin
                    pkt   <= rdata;
                    busy  <= 1'b1;
                    state <= LOAD;
                end
                LOAD: begin
                    byte_idx <= '0;
                    uart_tx  <= 1'b0;
                    state    <= START;
                end
                START: if (baud_end) begin
                    bit_idx <= '0;
                    uart_tx <= cur_byte[0];
                    state   <= DATA;
                end
                DATA: if (baud_end) begin
                    bit_idx <= bit_idx + 3'd1;
                    uart_tx <= bit_idx == 3'd7 ? 1'b1 : cur_byte[bit_idx + 3'd1];
                    state   <= bit_idx == 3'd7 ? STOP : DATA;
                end
                STOP: if (baud_end) begin
                    if (byte_idx < 4'(PKT_BYTES - 1)) begin
                        byte_idx <= byte_idx + 4'd1;
                        uart_tx  <= 1'b0;
                        state    <= START;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_retire_trace_uart.sv
// tb_retire_trace_uart: self-checking bench for retire_trace_uart (DEPTH=4, CLKS_PER_BIT=4)
module tb_retire_trace_uart;
    localparam int DEPTH = 4;
    localparam int CPB   = 4;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] wdata;
        logic [79:0] exp_pkt;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       uart_tx, busy, overflow;
    logic [2:0] fifo_count;
    logic [7:0] drop_count;
    int         n_tests = 0;
    int         n_fail = 0;
    int         cyc = 0;
    bit         mon_en = 1'b1;
    logic [7:0] exp_q [$];
    vec_t       vecs [4];

    retire_trace_uart_if tif ();

    retire_trace_uart #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .trace      (tif),
        .uart_tx    (uart_tx),
        .busy       (busy),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [79:0] mk_pkt(logic [31:0] pc, logic [4:0] rd, logic [31:0] wd);
        return {8'hA5, 3'b000, rd, pc[7:0], pc[15:8], pc[23:16], pc[31:24],
                wd[7:0], wd[15:8], wd[23:16], wd[31:24]};
    endfunction

    task automatic push_exp(logic [79:0] p);
        for (int i = 0; i < 10; i++) exp_q.push_back(p[79 - 8*i -: 8]);
    endtask

    // Presents one record for the next rising edge; returns 1 unit after that edge
    task automatic drive(logic [31:0] pc, logic [4:0] rd, logic [31:0] wd);
        tif.valid = 1'b1;
        tif.pc    = pc;
        tif.rd    = rd;
        tif.wdata = wd;
        @(posedge clk);
        #1;
    endtask

    // sel=0 watches uart_tx, sel=1 watches busy; at = cycle stamp when level seen
    task automatic wait_sig(string name, bit sel, logic level, int max, output int at);
        for (int i = 0; i < max; i++) begin
            if ((sel ? busy : uart_tx) === level) begin
                at = cyc;
                return;
            end
            @(posedge clk);
            #1;
        end
        at = cyc;
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out after %0d cycles waiting for level %0b", name, max, level);
    endtask

    // UART receiver: mid-bit sampling, compares each byte against the scoreboard
    initial begin
        logic [7:0] b, e;
        logic       ok;
        wait (rst_n === 1'b1);
        forever begin
            @(negedge uart_tx);
            repeat (CPB/2) @(posedge clk);
            #1 ok = (uart_tx === 1'b0);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(posedge clk);
                #1 b[i] = uart_tx;
            end
            repeat (CPB) @(posedge clk);
            #1 ok = ok && (uart_tx === 1'b1);
            if (mon_en) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rx byte: got %02h, expected no byte", b);
                end else begin
                    e = exp_q.pop_front();
                    if (!ok || b !== e) begin
                        n_fail++;
                        $display("FAIL rx byte: got %02h framing_ok=%0b, expected %02h framing_ok=1", b, ok, e);
                    end
                end
            end
        end
    end

    initial begin
        int t0, t1, w, peak, lows;
        vecs[0] = '{32'h0000_0010, 5'd5,  32'hDEAD_BEEF, 80'hA5_05_10_00_00_00_EF_BE_AD_DE};
        vecs[1] = '{32'h8000_1234, 5'd31, 32'h0000_0000, 80'hA5_1F_34_12_00_80_00_00_00_00};
        vecs[2] = '{32'hFFFF_FFFC, 5'd0,  32'h1234_5678, 80'hA5_00_FC_FF_FF_FF_78_56_34_12};
        vecs[3] = '{32'h0000_ABCD, 5'd10, 32'h8000_0001, 80'hA5_0A_CD_AB_00_00_01_00_00_80};
        tif.valid = 1'b0;
        tif.pc    = '0;
        tif.rd    = '0;
        tif.wdata = '0;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset uart_tx", uart_tx, 1);
        check("reset busy", busy, 0);
        check("reset fifo_count", fifo_count, 0);
        check("reset overflow", overflow, 0);
        check("reset drop_count", drop_count, 0);

        foreach (vecs[i]) begin
            push_exp(vecs[i].exp_pkt);
            drive(vecs[i].pc, vecs[i].rd, vecs[i].wdata);
            tif.valid = 1'b0;
            check("count after push", fifo_count, 1);
            @(posedge clk);
            #1;
            check("busy at pop edge", busy, 1);
            check("count after pop", fifo_count, 0);
            check("tx high in LOAD", uart_tx, 1);
            @(posedge clk);
            #1;
            check("start bit at push+2", uart_tx, 0);
            t0 = cyc;
            wait_sig("start bit end", 1'b0, 1'b1, 20, t1);
            check("start bit width", t1 - t0, CPB);
            wait_sig("bit0 end", 1'b0, 1'b0, 20, w);
            check("bit0 width", w - t1, CPB);
            wait_sig("packet end", 1'b1, 1'b0, 200*CPB, t1);
            check("packet length", t1 - t0, 100*CPB);
            repeat (2) @(posedge clk);
            #1;
            check("vector bytes drained", exp_q.size(), 0);
        end

        peak = 0;
        for (int k = 0; k < 3; k++) begin
            push_exp(mk_pkt(32'h100 + 32'(4*k), 5'(k + 1), 32'h1111_1111 * 32'(k + 1)));
            drive(32'h100 + 32'(4*k), 5'(k + 1), 32'h1111_1111 * 32'(k + 1));
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
        end
        tif.valid = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
        end
        check("b2b count peak", peak, 2);
        for (int k = 0; k < 2; k++) begin
            wait_sig("b2b busy fall", 1'b1, 1'b0, 200*CPB, t0);
            wait_sig("b2b next start", 1'b0, 1'b0, 20, t1);
            check("b2b idle gap", t1 - t0, 2);
        end
        wait_sig("b2b done", 1'b1, 1'b0, 200*CPB, t0);
        repeat (2) @(posedge clk);
        #1;
        check("b2b bytes drained", exp_q.size(), 0);

        for (int k = 0; k < 20; k++) begin
            if (k < 5) push_exp(mk_pkt(32'h2000 + 32'(k), 5'(k), 32'hC0DE_0000 + 32'(k)));
            drive(32'h2000 + 32'(k), 5'(k), 32'hC0DE_0000 + 32'(k));
        end
        tif.valid = 1'b0;
        check("burst drop_count", drop_count, 15);
        check("burst overflow", overflow, 1);
        check("burst fifo_count", fifo_count, DEPTH);
        for (int k = 0; k < 5; k++) begin
            wait_sig("burst packet end", 1'b1, 1'b0, 200*CPB, t0);
            @(posedge clk);
            #1;
        end
        check("burst fifo drained", fifo_count, 0);
        check("burst bytes drained", exp_q.size(), 0);

        for (int k = 0; k < 300; k++) begin
            if (k < 5) push_exp(mk_pkt(32'h3000 + 32'(k), 5'(k + 8), 32'(k) << 8));
            drive(32'h3000 + 32'(k), 5'(k + 8), 32'(k) << 8);
        end
        tif.valid = 1'b0;
        check("saturated drop_count", drop_count, 255);
        check("saturated overflow", overflow, 1);
        for (int k = 0; k < 5; k++) begin
            wait_sig("sat packet end", 1'b1, 1'b0, 200*CPB, t0);
            @(posedge clk);
            #1;
        end
        check("sat bytes drained", exp_q.size(), 0);
        check("drop_count holds", drop_count, 255);

        mon_en = 1'b0;
        drive(32'h0, 5'd3, 32'h0);
        tif.valid = 1'b0;
        wait_sig("reset test start", 1'b0, 1'b0, 20, t0);
        repeat (130) @(posedge clk);
        #1;
        check("line low in byte 3", uart_tx, 0);
        #2 rst_n = 1'b0;
        #1;
        check("async reset uart_tx", uart_tx, 1);
        check("async reset busy", busy, 0);
        check("async reset overflow", overflow, 0);
        check("async reset drop_count", drop_count, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        lows = 0;
        repeat (500) begin
            @(posedge clk);
            #1;
            if (uart_tx !== 1'b1 || busy !== 1'b0) lows++;
        end
        check("idle after reset release", lows, 0);
        check("fifo empty after reset", fifo_count, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/retire_trace_uart.md
# retire_trace_uart

Commit-trace capture block that sits directly downstream of `riscv_processor`. It samples one record per retired register write-back (PC, destination register, write data) from the processor's debug outputs. Records are buffered in a small FIFO and streamed out as framed 10-byte packets over an 8N1 UART TX pin, so a host can log execution on the iceBlinkPico without a JTAG probe. The block is strictly an observer and never back-pressures the core; records that do not fit are dropped and counted.

## Interface
- `DEPTH`, 8: FIFO entries; must be a power of two, ≥2.
- `CLKS_PER_BIT`, 104: clock cycles per UART bit (12 MHz / 115200); must be ≥2.
- `clk` input 1: single system clock.
- `rst_n` input 1: asynchronous, active-low reset. All state clears immediately on assertion.
- `trace_valid` input 1: one-cycle pulse per retirement. The core drives it from its write-back `reg_write`.
- `trace_pc` input 32: PC of the retiring instruction.
- `trace_rd` input 5: destination register (`debug_rd`).
- `trace_wdata` input 32: write-back value (`debug_wdata`).
- `uart_tx` output 1: serial output, idle high.
- `busy` output 1: high whenever the serializer is not in IDLE.
- `fifo_count` output $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `overflow` output 1: sticky; set on the first dropped record, cleared only by reset.
- `drop_count` output 8: dropped-record counter, saturating at 255.

## Operation
- Record = {rd[4:0], pc[31:0], wdata[31:0]}, stored as 69 bits per entry.
- Push: when `trace_valid`=1 and the FIFO is not full, the record is written on the rising edge. `trace_valid` is sampled every cycle, with no handshake.
- Full with `trace_valid`=1:
  - If a pop occurs in the same cycle, the push is accepted (count unchanged).
  - Otherwise the record is dropped, `overflow` is set, and `drop_count` increments if it is below 255.
- Packet byte order (each byte sent LSB-first):
  - byte 0: sync `0xA5`
  - byte 1: {3'b000, rd}
  - bytes 2–5: pc, least-significant byte first
  - bytes 6–9: wdata, least-significant byte first
- Each byte frame: 1 start bit (0), 8 data bits, 1 stop bit (1). Bytes within a packet are back-to-back, with no idle gap.
- Serializer states:
  - IDLE: `uart_tx`=1. If the FIFO is non-empty, pop and go to LOAD.
  - LOAD: latch the popped record into the packet register, set byte_idx=0, go to START.
  - START: `uart_tx`=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA: `uart_tx`=current byte[bit_idx] for CLKS_PER_BIT cycles per bit. After bit 7, go to STOP.
  - STOP: `uart_tx`=1 for CLKS_PER_BIT cycles. If byte_idx<9, increment it and go to START; otherwise go to IDLE.
- FIFO read/write pointers wrap modulo DEPTH. `fifo_count` is updated by push/pop on the same edge.

## Timing
- Reset values:
  - `uart_tx`=1, `busy`=0, `fifo_count`=0, `overflow`=0, `drop_count`=0.
  - State=IDLE; pointers, bit counter and baud counter all 0.
- Latency: for a record pushed at edge N into an empty FIFO with the serializer idle:
  - pop at edge N+1;
  - `uart_tx` falls at edge N+2.
- Packet length: 100·CLKS_PER_BIT cycles from the start-bit edge to the end of the final stop bit.
- Minimum idle-high gap between consecutive packets: 2 cycles (IDLE + LOAD).
- `busy` rises at the pop edge and falls at the edge that enters IDLE.
- Reset mid-packet: `uart_tx` returns high asynchronously and the partial packet is abandoned. FIFO contents are lost.
- No combinational path from any input to any output.

## Structure
- Shared package `trace_pkg`:
  - `trace_rec_t` packed struct (rd, pc, wdata);
  - `SYNC_BYTE` = 8'hA5;
  - `PKT_BYTES` = 10;
  - serializer state enum `tx_state_t`.
- Sub-module `trace_fifo`: synchronous FIFO, parameterized by DEPTH and the `trace_rec_t` width. It exposes full, empty and count, and accepts a simultaneous push+pop when full.
- Top level holds the drop logic and the serializer FSM.

## Test plan
- **Reset:** hold `rst_n`=0, then release → `uart_tx`=1, `fifo_count`=0, `overflow`=0, `drop_count`=0, `busy`=0.
- **Single record:** pc=0x00000010, rd=5, wdata=0xDEADBEEF.
  - Decoded bytes must be A5 05 10 00 00 00 EF BE AD DE.
  - Start bit falls 2 cycles after the push edge.
  - Each bit is exactly CLKS_PER_BIT cycles (run with CLKS_PER_BIT=4).
- **Back-to-back retirement:** 3 pulses on consecutive cycles → `fifo_count` peaks at 2 (one popped), three packets in order, 2-cycle gaps.
- **Overflow:** DEPTH=4, 20 pulses in a burst → 1 popped, 4 buffered, `drop_count`=15, `overflow`=1. After 5 packets `fifo_count`=0.
- **Saturation:** 300 drops → `drop_count` holds at 255.
- **Reset mid-packet:** assert `rst_n` during byte 3 → `uart_tx`=1 immediately. After release with no new pulses, the line stays idle.
